// File: rtl/uart_hash_rx_pkg.sv
// ============================================================================
// uart_hash_rx_pkg : shared constants and state encoding for the hash receiver
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_hash_rx_pkg;

    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] RESP_OK   = "K";
    localparam logic [7:0] RESP_ERR  = "?";
    localparam logic [7:0] RESP_BUSY = "B";

    localparam logic [127:0] DEFAULT_HASH = 128'he8cd0953abdfde433dfec7faa70df7f6;

    typedef enum logic [1:0] {
        S_HEX   = 2'd0,
        S_EOL   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_hash_rx_if.sv
// ============================================================================
// uart_hash_rx_if : uart byte strobes, hash commit and status-byte handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_hash_rx_if #(
    parameter int HEX_DIGITS = 32
);
    logic                    received;
    logic [7:0]              rx_byte;
    logic                    recv_error;
    logic                    lock;
    logic [4*HEX_DIGITS-1:0] hash;
    logic                    hash_valid;
    logic                    resp_valid;
    logic [7:0]              resp_byte;
    logic                    resp_ready;

    modport master (
        output received, rx_byte, recv_error, lock, resp_ready,
        input  hash, hash_valid, resp_valid, resp_byte
    );

    modport slave (
        input  received, rx_byte, recv_error, lock, resp_ready,
        output hash, hash_valid, resp_valid, resp_byte
    );
endinterface

`default_nettype wire

// File: rtl/uart_hash_rx_hex_char_decode.sv
// ============================================================================
// uart_hash_rx_hex_char_decode : ASCII to {is_hex, is_eol, nibble} classifier
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_hash_rx_hex_char_decode
    import uart_hash_rx_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic       is_eol,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        is_eol = (ch == CR) || (ch == LF);
        if (ch >= "0" && ch <= "9") begin
            is_hex = 1'b1;
            nibble = ch[3:0];
        end else if ((ch >= "a" && ch <= "f") || (ch >= "A" && ch <= "F")) begin
            // low nibble of 'a'/'A' is 1, so +9 maps the letters onto 10..15
            is_hex = 1'b1;
            nibble = ch[3:0] + 4'd9;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_hash_rx.sv
// ============================================================================
// uart_hash_rx : parses a line of hex characters from the uart into the target
//                hash, commits it with a one-cycle pulse and returns a status byte
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_hash_rx #(
    parameter int                    HEX_DIGITS    = 32,
    parameter logic [4*HEX_DIGITS-1:0] DEFAULT_HASH = uart_hash_rx_pkg::DEFAULT_HASH,
    parameter int unsigned           TIMEOUT_TICKS = 100_000_000
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_hash_rx_if.slave  bus
);
    import uart_hash_rx_pkg::*;

    localparam int          HASH_W = 4 * HEX_DIGITS;
    localparam int          CNT_W  = $clog2(HEX_DIGITS + 1);
    localparam logic [31:0] TO_MAX = TIMEOUT_TICKS;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HEX_DIGITS - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [HASH_W-1:0]   sreg, sreg_nxt;
    logic [31:0]         tcnt;

    logic                is_hex, is_eol;
    logic [3:0]          nibble;
    logic                strobe, bad, timeout_hit;
    logic                issue, commit;
    logic [7:0]          issue_byte;

    uart_hash_rx_hex_char_decode u_decode (
        .ch     (bus.rx_byte),
        .is_hex (is_hex),
        .is_eol (is_eol),
        .nibble (nibble)
    );

    // A framing error, alone or alongside a byte, always counts as a bad character
    assign strobe      = bus.received | bus.recv_error;
    assign bad         = bus.recv_error | ~(is_hex | is_eol);
    assign timeout_hit = (tcnt == TO_MAX);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sreg_nxt   = sreg;
        issue      = 1'b0;
        issue_byte = RESP_ERR;
        commit     = 1'b0;
        if (strobe) begin
            case (state)
                S_HEX: begin
                    if (!bad && is_hex) begin
                        sreg_nxt = {sreg[HASH_W-5:0], nibble};
                        cnt_nxt  = cnt + 1'b1;
                        if (cnt == LAST_IDX) state_nxt = S_EOL;
                    end else if (!bad && is_eol) begin
                        // blank lines and the LF of CRLF are silently skipped
                        if (cnt != '0) begin
                            issue   = 1'b1;
                            cnt_nxt = '0;
                        end
                    end else begin
                        issue     = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_FLUSH;
                    end
                end
                S_EOL: begin
                    issue   = 1'b1;
                    cnt_nxt = '0;
                    if (!bad && is_eol) begin
                        commit     = 1'b1;
                        issue_byte = bus.lock ? RESP_BUSY : RESP_OK;
                        state_nxt  = S_HEX;
                    end else begin
                        state_nxt = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!bad && is_eol) begin
                        state_nxt = S_HEX;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_HEX;
                    cnt_nxt   = '0;
                end
            endcase
        end else if (timeout_hit && (state != S_HEX || cnt != '0)) begin
            state_nxt = S_HEX;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_HEX;
            cnt   <= '0;
            sreg  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
            if (strobe)           tcnt <= '0;
            else if (!timeout_hit) tcnt <= tcnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.hash       <= DEFAULT_HASH;
            bus.hash_valid <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_byte  <= RESP_OK;
        end else begin
            bus.hash_valid <= commit & ~bus.lock;
            if (commit && !bus.lock) bus.hash <= sreg;
            // a fresh status always wins over a pending or accepted one
            if (issue) begin
                bus.resp_valid <= 1'b1;
                bus.resp_byte  <= issue_byte;
            end else if (bus.resp_valid && bus.resp_ready) begin
                bus.resp_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
